// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath (Booth multiplier and divider).
package arith_pkg;

  // Default operand width shared by the multiplier and the divider
  localparam int ARITH_N = 4;

  // Divider controller state encoding
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div_abs.sv
// Combinational two's-complement conditional negate.
// With negate tied to the operand's sign bit, it produces the magnitude.
// The magnitude of the most negative value reads correctly as an unsigned number.
module seq_div_abs #(
  parameter int W = 4
) (
  input  logic [W-1:0] value_in,
  input  logic         negate,
  output logic [W-1:0] value_out
);

  // Pass the value through, or return its two's-complement negation
  always_comb begin
    value_out = negate ? -value_in : value_in;
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: a 2N-bit dividend divided by an N-bit divisor.
// It does restoring shift-subtract on the operand magnitudes, then a sign-fix cycle.
// Optional build macro SEQ_DIV_OVF_DETECT_EN compiles in quotient-overflow detection.
// Without the macro, ovf is always 0.
module seq_signed_divider
  import arith_pkg::*;
#(
  parameter int N = ARITH_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           dbz,
  output logic           ovf
);

  localparam int             CW    = $clog2(2*N+1);
  localparam logic [CW-1:0]  ITERS = CW'(2*N);

  div_state_e     state_q, state_d;
  logic [2*N-1:0] dvd_q, dvd_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dvd_neg_q, dvd_neg_d;
  logic           dvs_neg_q, dvs_neg_d;
  logic           dbz_pend_q, dbz_pend_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;

  logic [2*N-1:0] dvd_mag;
  logic [N-1:0]   dvs_mag;
  logic [N-1:0]   quo_signed;
  logic [N-1:0]   rem_signed;
  logic [N:0]     rem_shift;
  logic           rem_ge;
  logic [N-1:0]   rem_diff;
  logic           ovf_calc;

  // Operand conditioning: magnitudes of the incoming dividend and divisor
  seq_div_abs #(.W(2*N)) u_dvd_abs (
    .value_in  (dividend),
    .negate    (dividend[2*N-1]),
    .value_out (dvd_mag)
  );

  seq_div_abs #(.W(N)) u_dvs_abs (
    .value_in  (divisor),
    .negate    (divisor[N-1]),
    .value_out (dvs_mag)
  );

  // Sign correction: only the low N bits of each result are reported
  seq_div_abs #(.W(N)) u_quo_fix (
    .value_in  (dvd_q[N-1:0]),
    .negate    (dvd_neg_q ^ dvs_neg_q),
    .value_out (quo_signed)
  );

  seq_div_abs #(.W(N)) u_rem_fix (
    .value_in  (rem_q),
    .negate    (dvd_neg_q),
    .value_out (rem_signed)
  );

  // One restoring step: shift in the next dividend bit, then trial-subtract the divisor
  always_comb begin
    rem_shift = {rem_q, dvd_q[2*N-1]};
    rem_ge    = rem_shift >= {1'b0, dvs_q};
    rem_diff  = N'(rem_shift - {1'b0, dvs_q});
  end

`ifdef SEQ_DIV_OVF_DETECT_EN
  localparam logic [2*N-1:0] QMAG_POS_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] QMAG_NEG_MAX = QMAG_POS_MAX + 1'b1;

  // Overflow: the quotient magnitude does not fit the signed N-bit range for its sign
  always_comb begin
    ovf_calc = (dvd_neg_q ^ dvs_neg_q) ? (dvd_q > QMAG_NEG_MAX)
                                       : (dvd_q > QMAG_POS_MAX);
  end
`else
  // Overflow detection is not built, so the flag stays low
  always_comb begin
    ovf_calc = 1'b0;
  end
`endif

  // Controller next state: accept, iterate 2N times, then sign-fix and report
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    dbz_pend_d  = dbz_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          dvd_d      = dvd_mag;
          dvs_d      = dvs_mag;
          dvd_neg_d  = dividend[2*N-1];
          dvs_neg_d  = divisor[N-1];
          rem_d      = '0;
          cnt_d      = ITERS;
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          dbz_pend_d = (divisor == '0);
          state_d    = (divisor == '0) ? DIV_FIX : DIV_RUN;
        end
      end
      DIV_RUN: begin
        rem_d = rem_ge ? rem_diff : rem_shift[N-1:0];
        dvd_d = {dvd_q[2*N-2:0], rem_ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DIV_IDLE;
        if (dbz_pend_q) begin
          quotient_d  = '0;
          remainder_d = '0;
          dbz_d       = 1'b1;
          ovf_d       = 1'b0;
        end else begin
          quotient_d  = quo_signed;
          remainder_d = rem_signed;
          dbz_d       = 1'b0;
          ovf_d       = ovf_calc;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any division in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      dbz_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      dbz_pend_q  <= dbz_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule
